// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: instruction issue / register-file stage feeding the ALU and PSR.
// Accepts one 16-bit instruction per two cycles (IDLE -> EXEC -> IDLE), reads
// operands from a 16x16 register file, drives registered ALU operands and a
// one-hot alu_sel, and writes the ALU result back at the closing EXEC edge.
// Optional feature: define ALU_LUI_EN to make op 8 a legal LUI; otherwise op 8
// is treated as illegal.
module alu_issue_ctrl (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [5:0]  alu_sel,
    input  logic [15:0] alu_out,
    output logic        illegal,
    output logic [15:0] retired,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    localparam logic [3:0] OpNop = 4'd0;
    localparam logic [3:0] OpAdd = 4'd1;
    localparam logic [3:0] OpSub = 4'd2;
    localparam logic [3:0] OpCmp = 4'd3;
    localparam logic [3:0] OpAnd = 4'd4;
    localparam logic [3:0] OpOr  = 4'd5;
    localparam logic [3:0] OpXor = 4'd6;
    localparam logic [3:0] OpLdi = 4'd7;
    localparam logic [3:0] OpLui = 4'd8;

    state_e      state_q, state_d;
    logic [15:0] ir_q;
    logic [15:0] rf_q [16];
    logic [15:0] alu_a_q, alu_b_q;
    logic [5:0]  alu_sel_q;
    logic [15:0] retired_q;

    logic        accept;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        count_en;
    logic [15:0] rd_a, rd_b;

    logic [3:0]  ir_op;
    logic [3:0]  ir_rd;
    logic [7:0]  ir_imm;

    assign ir_op  = ir_q[15:12];
    assign ir_rd  = ir_q[11:8];
    assign ir_imm = ir_q[7:0];

    // One-hot ALU select; zero for NOP, immediates and illegal ops.
    function automatic logic [5:0] op_sel(input logic [3:0] op);
        logic [5:0] sel;
        sel = 6'b000000;
        case (op)
            OpAdd:   sel = 6'b100000;
            OpSub:   sel = 6'b010000;
            OpCmp:   sel = 6'b001000;
            OpAnd:   sel = 6'b000100;
            OpOr:    sel = 6'b000010;
            OpXor:   sel = 6'b000001;
            default: sel = 6'b000000;
        endcase
        return sel;
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_LUI_EN
        return op <= OpLui;
`else
        return op <= OpLdi;
`endif
    endfunction

    // Operand read ports; R0 reads as zero.
    assign rd_a = (instr[3:0] == 4'd0) ? 16'h0000 : rf_q[instr[3:0]];
    assign rd_b = (instr[7:4] == 4'd0) ? 16'h0000 : rf_q[instr[7:4]];

    // Next-state and handshake decode.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        illegal     = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                illegal = !op_legal(ir_op);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Writeback and retire decode for the closing EXEC edge.
    always_comb begin
        wr_en    = 1'b0;
        wr_data  = alu_out;
        count_en = 1'b0;
        if (state_q == StExec) begin
            count_en = op_legal(ir_op) && (ir_op != OpNop);
            case (ir_op)
                OpAdd, OpSub, OpAnd, OpOr, OpXor: wr_en = 1'b1;
                OpLdi: begin
                    wr_en   = 1'b1;
                    wr_data = {8'h00, ir_imm};
                end
`ifdef ALU_LUI_EN
                OpLui: begin
                    wr_en   = 1'b1;
                    wr_data = {ir_imm, rf_q[ir_rd][7:0]};
                end
`endif
                default: wr_en = 1'b0;
            endcase
            // Writes to R0 are discarded.
            if (ir_rd == 4'd0) begin
                wr_en = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction latch and registered ALU operands/select.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ir_q      <= 16'h0000;
            alu_a_q   <= 16'h0000;
            alu_b_q   <= 16'h0000;
            alu_sel_q <= 6'b000000;
        end else if (accept) begin
            ir_q      <= instr;
            alu_a_q   <= rd_a;
            alu_b_q   <= rd_b;
            alu_sel_q <= op_sel(instr[15:12]);
        end else if (state_q == StExec) begin
            // Operands hold; only the select drops back to no-op.
            alu_sel_q <= 6'b000000;
        end
    end

    // Register file writeback.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else if (wr_en) begin
            rf_q[ir_rd] <= wr_data;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            retired_q <= 16'h0000;
        end else if (count_en) begin
            retired_q <= retired_q + 16'h0001;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign retired  = retired_q;
    assign dbg_data = (dbg_addr == 4'd0) ? 16'h0000 : rf_q[dbg_addr];

endmodule
